branch_target_search: RTL and testbench

Programmable branch-target table with a sequential reverse-lookup engine. Software or the loader writes 10-bit PC targets into 32 indexed entries. The fetch stage reads a target by index combinationally. The assembler/debug path submits a PC target and receives the lowest index holding it, so jump fields can be encoded in hardware. The block sits beside the PC/fetch logic as the writable counterpart of the fixed target lookup.

---
 rtl/branch_target_search.sv | 94 +++++++++
 tb/tb_branch_target_search.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_search.sv
// branch_target_search: writable branch-target table with a sequential reverse-lookup engine.
//
// Forward path: rd_addr -> rd_target/rd_valid combinationally (rd_target is 0 for an invalid entry).
// Write path:   wr_en/wr_addr/wr_target write an entry and mark it valid; clr_all invalidates
//               every entry (data untouched). Clear applies before a same-cycle write.
// Search path:  req_valid/req_ready/req_target hand in a value; the engine scans the table from
//               index 0 upward and returns rsp_hit/rsp_index (lowest matching index, 0 on miss)
//               under rsp_valid/rsp_ready.
// Clk rising edge; Reset_n asynchronous active-low.
// Macro BTS_DUAL_COMPARE_EN: when defined, each scan cycle compares an even/odd entry pair,
// halving search latency; the lower index wins when both match.
module branch_target_search #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 10,
    parameter int DEPTH  = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TGT_W-1:0]  wr_target,
    input  logic              clr_all,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TGT_W-1:0]  rd_target,
    output logic              rd_valid,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TGT_W-1:0]  req_target,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_index
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t state;
    logic [TGT_W-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [TGT_W-1:0] tgt;
    logic [ADDR_W-1:0] ptr, i0, i1;
    logic m0, m1, last;
`ifdef BTS_DUAL_COMPARE_EN
    localparam int LAST = DEPTH / 2 - 1;
    assign i0 = {ptr[ADDR_W-2:0], 1'b0};
    assign i1 = {ptr[ADDR_W-2:0], 1'b1};
    assign m1 = valid[i1] && data[i1] == tgt;
`else
    localparam int LAST = DEPTH - 1;
    assign i0 = ptr;
    assign i1 = ptr;
    assign m1 = 1'b0;
`endif
    // Compares use the registered table, so a write landing this cycle is not seen.
    assign m0 = valid[i0] && data[i0] == tgt;
    assign last = ptr == ADDR_W'(LAST);
    assign rd_valid = valid[rd_addr];
    assign rd_target = rd_valid ? data[rd_addr] : '0;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    // clr_all first, then the write, so a same-cycle write leaves its entry valid.
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
        end else begin
            if (clr_all) valid <= '0;
            if (wr_en) begin
                valid[wr_addr] <= 1'b1;
                data[wr_addr] <= wr_target;
            end
        end
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            state <= IDLE;
            ptr <= '0;
            tgt <= '0;
            rsp_hit <= 1'b0;
            rsp_index <= '0;
        end else
            case (state)
                IDLE: if (req_valid) begin
                    tgt <= req_target;
                    ptr <= '0;
                    state <= SCAN;
                end
                SCAN: if (m0 || m1 || last) begin
                    rsp_hit <= m0 || m1;
                    rsp_index <= m0 ? i0 : m1 ? i1 : '0;
                    state <= RESP;
                end else
                    ptr <= ptr + 1'b1;
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_branch_target_search.sv
// tb_branch_target_search: randomized + directed scoreboard bench for branch_target_search.
module tb_branch_target_search;
    localparam int AW = 5;
    localparam int TW = 10;
    localparam int DEPTH = 32;
`ifdef BTS_DUAL_COMPARE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    logic Clk = 0, Reset_n = 0;
    logic wr_en = 0, clr_all = 0, req_valid = 0, rsp_ready = 0;
    logic [AW-1:0] wr_addr = 0, rd_addr = 0, rsp_index;
    logic [TW-1:0] wr_target = 0, req_target = 0, rd_target;
    logic rd_valid, req_ready, rsp_valid, rsp_hit;
    int checks = 0, errors = 0, cyc = 0;
    bit force_low = 0;
    typedef struct { logic hit; logic [AW-1:0] idx; int due; } exp_t;
    exp_t sbq[$];
    logic [TW-1:0] mdata [DEPTH];
    logic mvalid [DEPTH];

    branch_target_search dut (
        .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_target(wr_target),
        .clr_all(clr_all), .rd_addr(rd_addr), .rd_target(rd_target), .rd_valid(rd_valid),
        .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Table contents as software sees them: clear, then write.
    always @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mvalid[i] <= 1'b0;
                mdata[i] <= '0;
            end
        end else begin
            if (clr_all) for (int i = 0; i < DEPTH; i++) mvalid[i] <= 1'b0;
            if (wr_en) begin
                mvalid[wr_addr] <= 1'b1;
                mdata[wr_addr] <= wr_target;
            end
        end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", n, a, e);
        end
    endtask

    function automatic logic [TW-1:0] pool();
        return 10'h100 + 10'($urandom_range(0, 5));
    endfunction

    task automatic wr(input int a, input logic [TW-1:0] v, input bit clr);
        @(negedge Clk);
        wr_en = 1; wr_addr = AW'(a); wr_target = v; clr_all = clr;
        @(negedge Clk);
        wr_en = 0; clr_all = 0;
    endtask

    task automatic rd_all(input int only, input logic [TW-1:0] v);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            chk("rd_valid", rd_valid, a == only);
            chk("rd_target", rd_target, a == only ? v : '0);
        end
    endtask

    task automatic rd_model();
        int a = $urandom_range(0, DEPTH - 1);
        rd_addr = AW'(a);
        #1;
        chk("rd_valid_rand", rd_valid, mvalid[a]);
        chk("rd_target_rand", rd_target, mvalid[a] ? mdata[a] : '0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_wait", req_ready, 1);
    endtask

    // Scan cycle c examines entries c*STEP .. c*STEP+STEP-1 as the table stands during that cycle.
    task automatic search(input logic [TW-1:0] t, input int wc, input int wa, input logic [TW-1:0] wt,
                          input int abort_at, input bit rnd);
        int t0, fk;
        bit found;
        @(negedge Clk);
        req_valid = 1; req_target = t; wr_en = 0; clr_all = 0;
        @(negedge Clk);
        req_valid = 0;
        t0 = cyc;
        for (int c = 0; c < DEPTH / STEP; c++) begin
            if (c == abort_at) begin
                Reset_n = 0; wr_en = 0;
                @(negedge Clk);
                Reset_n = 1;
                return;
            end
            found = 0; fk = 0;
            for (int k = c * STEP; k < c * STEP + STEP; k++)
                if (!found && mvalid[k] && mdata[k] == t) begin
                    found = 1; fk = k;
                end
            if (found || c == DEPTH / STEP - 1) begin
                sbq.push_back('{found, AW'(fk), t0 + c + 1});
                wr_en = 0;
                return;
            end
            wr_en = (c == wc) || (rnd && $urandom_range(0, 3) == 0);
            wr_addr = c == wc ? AW'(wa) : AW'($urandom_range(0, DEPTH - 1));
            wr_target = c == wc ? wt : pool();
            @(negedge Clk);
        end
    endtask

    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge Clk);
            #2;
            rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops the scoreboard on each rising rsp_valid, checks hold and drop behaviour.
    initial begin
        bit pv = 0, pr = 0, hh = 0;
        logic [AW-1:0] hi = 0;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                pv = 0; pr = 0;
            end else begin
                if (pv && pr) chk("rsp_drop", rsp_valid, 0);
                else if (pv && rsp_valid) begin
                    chk("hold_hit", rsp_hit, hh);
                    chk("hold_index", rsp_index, hi);
                    chk("resp_req_ready", req_ready, 0);
                end else if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected got rsp_valid=1 exp no response");
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_hit", rsp_hit, e.hit);
                        chk("rsp_index", rsp_index, e.idx);
                        chk("rsp_cycle", cyc, e.due);
                    end
                    hh = rsp_hit; hi = rsp_index;
                end
                pv = rsp_valid; pr = rsp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge Clk);
        Reset_n = 1;
        @(negedge Clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_hit", rsp_hit, 0);
        chk("reset_rsp_index", rsp_index, 0);
        rd_all(-1, 0);
        wr(3, 10'h02C, 0);
        wr(5, 10'h02C, 0);
        search(10'h02C, -1, 0, 0, -1, 0);
        wait_idle();
        for (int a = 0; a < DEPTH; a++) wr(a, 10'h200 + 10'(a), 0);
        force_low = 1;
        search(10'h3FF, -1, 0, 0, -1, 0);
        repeat (6) @(negedge Clk);
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_req_ready", req_ready, 0);
        force_low = 0;
        wait_idle();
        search(10'h11F, 10 / STEP, 10, 10'h11F, -1, 0);
        wait_idle();
        wr(10, 10'h20A, 0);
        search(10'h11F, 8 / STEP, 10, 10'h11F, -1, 0);
        wait_idle();
        wr(7, 10'h047, 1);
        rd_all(7, 10'h047);
        search(10'h047, -1, 0, 0, -1, 0);
        wait_idle();
        wr(20, 10'h155, 0);
        search(10'h0AA, -1, 0, 0, 5, 0);
        repeat (3) @(negedge Clk);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        rd_all(-1, 0);
        repeat (40) begin
            repeat ($urandom_range(1, 4)) wr($urandom_range(0, DEPTH - 1), pool(), $urandom_range(0, 9) == 0);
            rd_model();
            search(pool(), -1, 0, 0, -1, 1);
            wait_idle();
            rd_model();
        end
        repeat (4) @(negedge Clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
